// File: rtl/ram_bus_arbiter.sv
// Arbiter for the single-port program/data RAM shared by the CPU path and the debug/loader port.
// Every access is one ACCESS cycle followed by one DONE cycle. Grants are decided on the edges that leave IDLE or DONE.
module ram_bus_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic              CPU_GNT,
  output logic              CPU_ACK,
  output logic [DATA_W-1:0] CPU_RDATA,
  input  logic              DBG_REQ,
  input  logic              DBG_WE,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_WDATA,
  output logic              DBG_GNT,
  output logic              DBG_ACK,
  output logic [DATA_W-1:0] DBG_RDATA,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_RW,
  output logic              RAM_EN,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic              HALT
);
  localparam logic [3:0] MAX_HOLD_CNT = 4'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state_reg;
  logic       last_owner_reg;  // 0 = CPU, 1 = DBG
  logic [3:0] hold_cnt_reg;
  logic [3:0] hold_cnt_next;
  logic [1:0] req;
  logic       grant_valid;
  logic       grant_idx;
  logic       other_req;

  assign req = {DBG_REQ, CPU_REQ};

  always_comb begin
    grant_valid = |req;
    grant_idx   = DBG_REQ;
    if (&req) begin
      // The owner finishing in DONE may continue until it reaches its burst cap.
      if (state_reg == DONE && hold_cnt_reg < MAX_HOLD_CNT)
        grant_idx = last_owner_reg;
      else
        grant_idx = ~last_owner_reg;
    end
    other_req = req[~grant_idx];
    if (!other_req)
      hold_cnt_next = 4'd0;
    else if (grant_idx == last_owner_reg)
      hold_cnt_next = hold_cnt_reg + 4'd1;
    else
      hold_cnt_next = 4'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      last_owner_reg <= 1'b1;
      hold_cnt_reg   <= 4'd0;
      RAM_ADDR       <= '0;
      RAM_WDATA      <= '0;
      RAM_RW         <= 1'b0;
      RAM_EN         <= 1'b0;
    end else begin
      case (state_reg)
        ACCESS: begin
          RAM_EN    <= 1'b0;
          state_reg <= DONE;
        end
        default: begin
          hold_cnt_reg <= hold_cnt_next;
          if (grant_valid) begin
            RAM_ADDR       <= grant_idx ? DBG_ADDR : CPU_ADDR;
            RAM_WDATA      <= grant_idx ? DBG_WDATA : CPU_WDATA;
            RAM_RW         <= grant_idx ? DBG_WE : CPU_WE;
            RAM_EN         <= 1'b1;
            last_owner_reg <= grant_idx;
            state_reg      <= ACCESS;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  // Per-requester grant, completion pulse and read-data holding register.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic              gnt_reg;
      logic              ack_reg;
      logic [DATA_W-1:0] rdata_reg;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          gnt_reg   <= 1'b0;
          ack_reg   <= 1'b0;
          rdata_reg <= '0;
        end else if (state_reg == ACCESS) begin
          if (last_owner_reg == 1'(gi)) begin
            ack_reg <= 1'b1;
            if (!RAM_RW)
              rdata_reg <= RAM_RDATA;
          end
        end else begin
          ack_reg <= 1'b0;
          gnt_reg <= grant_valid && (grant_idx == 1'(gi));
        end
      end
    end
  endgenerate

  assign CPU_GNT   = g_port[0].gnt_reg;
  assign CPU_ACK   = g_port[0].ack_reg;
  assign CPU_RDATA = g_port[0].rdata_reg;
  assign DBG_GNT   = g_port[1].gnt_reg;
  assign DBG_ACK   = g_port[1].ack_reg;
  assign DBG_RDATA = g_port[1].rdata_reg;
  assign HALT      = DBG_REQ | DBG_GNT;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter: a transaction-level arbitration model queues expected accesses,
// and a negedge monitor checks the bus, grants, acks and read data against it.
module tb_ram_bus_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MH = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          cpu_gnt, cpu_ack, dbg_gnt, dbg_ack, ram_rw, ram_en, halt;
  logic [DW-1:0] cpu_rdata, dbg_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  ram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .CLK(clk), .RST(rst),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .CPU_GNT(cpu_gnt), .CPU_ACK(cpu_ack), .CPU_RDATA(cpu_rdata),
    .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wdata),
    .DBG_GNT(dbg_gnt), .DBG_ACK(dbg_ack), .DBG_RDATA(dbg_rdata),
    .RAM_ADDR(ram_addr), .RAM_WDATA(ram_wdata), .RAM_RW(ram_rw), .RAM_EN(ram_en),
    .RAM_RDATA(ram_rdata), .HALT(halt)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 16) ? 8'h5A : 8'(i * 37 + 11);
  endfunction

  // RAM behind the arbiter: combinational read, write on the rising edge while enabled.
  logic [DW-1:0] ram_mem [256];
  assign ram_rdata = ram_mem[ram_addr];
  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (ram_en && ram_rw) ram_mem[ram_addr] = ram_wdata;
    end
  end

  // Reference model: whole accesses, each two cycles long, granted by the round-robin/burst-cap rules.
  typedef struct {
    logic          own;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t          exp_q[$];
  logic [DW-1:0] ref_mem [256];
  int            m_phase = 0;      // 0 free, 1 access in flight, 2 access just completed
  logic          m_last  = 1'b1;   // previous owner, 1 = DBG
  int            m_hold  = 0;

  task automatic model_step();
    logic win, other, cont;
    txn_t t;
    if (rst) begin
      m_phase = 0; m_last = 1'b1; m_hold = 0;
      exp_q.delete();
      return;
    end
    if (m_phase == 1) begin
      m_phase = 2;
      return;
    end
    cont = (m_phase == 2);
    if (!cpu_req && !dbg_req) begin
      m_phase = 0; m_hold = 0;
      return;
    end
    if (cpu_req && dbg_req) win = (cont && m_hold < MH) ? m_last : !m_last;
    else                    win = dbg_req;
    other  = win ? cpu_req : dbg_req;
    m_hold = !other ? 0 : (win == m_last) ? m_hold + 1 : 1;
    t.own   = win;
    t.we    = win ? dbg_we : cpu_we;
    t.addr  = win ? dbg_addr : cpu_addr;
    t.wdata = win ? dbg_wdata : cpu_wdata;
    t.rdata = '0;
    if (t.we) ref_mem[t.addr] = t.wdata;
    else      t.rdata = ref_mem[t.addr];
    exp_q.push_back(t);
    m_last  = win;
    m_phase = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares DUT outputs with the model on every falling edge.
  logic [DW-1:0] exp_rdata_cpu = '0;
  logic [DW-1:0] exp_rdata_dbg = '0;
  int            grant_log[$];

  initial forever begin
    logic [1:0] exp_gnt;
    txn_t t;
    @(negedge clk);
    if (rst) begin
      check("reset_outputs", 32'({cpu_gnt, dbg_gnt, cpu_ack, dbg_ack, ram_en, ram_rw}), 32'd0);
      check("reset_rdata", 32'({cpu_rdata, dbg_rdata}), 32'd0);
      exp_rdata_cpu = '0;
      exp_rdata_dbg = '0;
    end else begin
      exp_gnt = (m_phase == 0) ? 2'b00 : (m_last ? 2'b10 : 2'b01);
      check("gnt", 32'({dbg_gnt, cpu_gnt}), 32'(exp_gnt));
      check("halt", 32'(halt), 32'(dbg_req | exp_gnt[1]));
      check("ram_en_timing", 32'(ram_en), 32'(m_phase == 1));
      check("ack_timing", 32'({dbg_ack, cpu_ack}), 32'((m_phase == 2) ? exp_gnt : 2'b00));
      if (ram_en) begin
        grant_log.push_back(int'(dbg_gnt));
        check("access_queue_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          t = exp_q[0];
          check("ram_addr", 32'(ram_addr), 32'(t.addr));
          check("ram_rw", 32'(ram_rw), 32'(t.we));
          check("ram_wdata", 32'(ram_wdata), 32'(t.wdata));
        end
      end
      if (cpu_ack || dbg_ack) begin
        check("ack_queue_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          t = exp_q.pop_front();
          check("ack_owner", 32'({dbg_ack, cpu_ack}), t.own ? 32'd2 : 32'd1);
          if (!t.we) begin
            if (t.own) exp_rdata_dbg = t.rdata;
            else       exp_rdata_cpu = t.rdata;
          end
        end
      end
      check("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata_cpu));
      check("dbg_rdata", 32'(dbg_rdata), 32'(exp_rdata_dbg));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int exp_seq[12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
  int exp_cap[7]  = '{0, 0, 0, 1, 1, 1, 0};

  initial begin
    repeat (3) step();
    check("reset_halt_low", 32'(halt), 32'd0);
    dbg_req = 1'b1;
    #1 check("reset_halt_follows_req", 32'(halt), 32'd1);
    dbg_req = 1'b0;
    rst = 1'b0;
    step();

    // CPU read of a preloaded location, debug port idle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    step();
    check("cpu_read_en", 32'(ram_en), 32'd1);
    check("cpu_read_addr", 32'(ram_addr), 32'h10);
    check("cpu_read_halt", 32'(halt), 32'd0);
    cpu_req = 1'b0;
    step();
    check("cpu_read_ack", 32'(cpu_ack), 32'd1);
    check("cpu_read_data", 32'(cpu_rdata), 32'h5A);
    step();
    check("cpu_read_ack_drop", 32'(cpu_ack), 32'd0);

    // Debug write, then CPU reads it back
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h22; dbg_wdata = 8'hC3;
    #1 check("dbg_req_halt", 32'(halt), 32'd1);
    step();
    dbg_req = 1'b0; dbg_we = 1'b0;
    #1 check("dbg_gnt_halt", 32'(halt), 32'd1);
    step();
    check("dbg_write_ack", 32'(dbg_ack), 32'd1);
    check("dbg_write_rdata_kept", 32'(dbg_rdata), 32'd0);
    step();
    check("halt_release", 32'(halt), 32'd0);
    cpu_req = 1'b1; cpu_addr = 8'h22;
    step();
    cpu_req = 1'b0;
    step();
    check("cpu_readback", 32'(cpu_rdata), 32'hC3);
    step();

    // Simultaneous back-to-back reads from reset: CPU first, bursts of MAX_HOLD
    rst = 1'b1;
    step();
    rst = 1'b0;
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0;
    grant_log.delete();
    repeat (24) begin
      cpu_addr = 8'($urandom_range(0, 63));
      dbg_addr = 8'($urandom_range(0, 63));
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    for (int i = 0; i < 12; i++)
      check($sformatf("tie_seq_%0d", i), (i < grant_log.size()) ? 32'(grant_log[i]) : 32'd9, 32'(exp_seq[i]));
    repeat (3) step();

    // Starvation cap: CPU bursting alone, DBG arrives mid-burst
    cpu_req = 1'b1;
    repeat (8) begin
      cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
      step();
    end
    grant_log.delete();
    dbg_req = 1'b1;
    repeat (16) begin
      cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
      dbg_addr = 8'($urandom_range(0, 15));
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    for (int i = 0; i < 7; i++)
      check($sformatf("cap_seq_%0d", i), (i < grant_log.size()) ? 32'(grant_log[i]) : 32'd9, 32'(exp_cap[i]));
    repeat (3) step();

    // Reset while an access is in flight
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
    step();
    check("midreset_precondition", 32'({ram_en, cpu_gnt}), 32'd3);
    #1 rst = 1'b1;
    #1 check("midreset_outputs", 32'({ram_en, cpu_gnt, dbg_gnt, cpu_ack, dbg_ack}), 32'd0);
    step();
    rst = 1'b0;
    dbg_req = 1'b1;
    step();
    check("post_reset_tie_cpu", 32'({dbg_gnt, cpu_gnt}), 32'd1);
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (3) step();

    // Randomised traffic
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) cpu_req = ~cpu_req;
      if ($urandom_range(0, 4) == 0) dbg_req = ~dbg_req;
      cpu_we = ($urandom_range(0, 2) == 0); dbg_we = ($urandom_range(0, 2) == 0);
      cpu_addr = 8'($urandom_range(0, 15)); dbg_addr = 8'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom); dbg_wdata = 8'($urandom);
      step();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (4) step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
